// File: rtl/fetch_queue_pkg.sv
// Shared types and core defaults for the fetch-to-decode queue.
// Entry layout is {pc, instr}; widths derive from the struct.
package fetch_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   localparam int FQ_DATA_W = $bits(fq_entry_t);
   localparam int FQ_DEPTH  = 8;
   localparam int FQ_IN_W   = 2;
   localparam int FQ_OUT_W  = 2;

endpackage

// File: rtl/fq_lane_count.sv
// Combinational popcount of a thermometer-coded lane vector.
// Used for push lane counts and for clipped pop counts.
module fq_lane_count #(
   parameter int W = 2,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] num
);

   always_comb begin
      num = '0;
      for (int i = 0; i < W; i++) begin
         num = num + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane circular instruction queue between Fetch and Decode.
// Zero-latency read of head lanes; all-or-nothing group push.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DATA_W = FQ_DATA_W,
   parameter int DEPTH  = FQ_DEPTH,
   parameter int IN_W   = FQ_IN_W,
   parameter int OUT_W  = FQ_OUT_W,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int TW = $clog2(OUT_W + 1),
   localparam int NW = $clog2(IN_W + 1)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    flush,
   input  logic [IN_W-1:0]         in_valid,
   input  logic [IN_W*DATA_W-1:0]  in_data,
   output logic                    in_ready,
   output logic [OUT_W-1:0]        out_valid,
   output logic [OUT_W*DATA_W-1:0] out_data,
   input  logic [TW-1:0]           out_take,
   output logic [CW-1:0]           count
);

   if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_pow2
      $error("fetch_queue: DEPTH must be a power of 2");
   end
   if (DEPTH < IN_W) begin : g_chk_in
      $error("fetch_queue: DEPTH must be >= IN_W");
   end
   if (DEPTH < OUT_W) begin : g_chk_out
      $error("fetch_queue: DEPTH must be >= OUT_W");
   end
   if (IN_W < 1 || OUT_W < 1) begin : g_chk_lanes
      $error("fetch_queue: IN_W and OUT_W must be >= 1");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     cnt;

   logic              push;
   logic [NW-1:0]     npush;
   logic [OUT_W-1:0]  take_mask;
   logic [TW-1:0]     ntake;

   // Masking keeps the DEPTH==1 case in range; otherwise a no-op.
   function automatic logic [PW-1:0] wrap(
      input logic [PW-1:0] p,
      input int unsigned   k
   );
      return PW'(p + PW'(k)) & PW'(DEPTH - 1);
   endfunction

   assign in_ready = (CW'(DEPTH) - cnt) >= CW'(IN_W);
   assign push     = in_ready & in_valid[0];
   assign count    = cnt;

   always_comb begin
      out_valid = '0;
      out_data  = '0;
      take_mask = '0;
      for (int i = 0; i < OUT_W; i++) begin
         out_valid[i] = cnt > CW'(i);
         out_data[i*DATA_W +: DATA_W] = mem[wrap(head, i)];
         take_mask[i] = out_valid[i] & (out_take > TW'(i));
      end
   end

   fq_lane_count #(.W(IN_W)) u_push_cnt (
      .vec (in_valid),
      .num (npush)
   );

   // Masking by out_valid clips the pop to what is present.
   fq_lane_count #(.W(OUT_W)) u_take_cnt (
      .vec (take_mask),
      .num (ntake)
   );

   always_ff @(posedge clk) begin
      if (resetn && !flush && push) begin
         for (int i = 0; i < IN_W; i++) begin
            if (in_valid[i]) begin
               mem[wrap(tail, i)] <= in_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= wrap(head, int'(ntake));
         if (push) begin
            tail <= wrap(tail, int'(npush));
            cnt  <= cnt + CW'(npush) - CW'(ntake);
         end else begin
            cnt  <= cnt - CW'(ntake);
         end
      end
   end

   a_thermo: assert property (
      @(posedge clk) disable iff (!resetn)
      ((in_valid & (in_valid + IN_W'(1))) == '0)
   ) else $error("fetch_queue: in_valid not thermometer");

   a_take: assert property (
      @(posedge clk) disable iff (!resetn)
      (out_take <= TW'(OUT_W))
   ) else $error("fetch_queue: out_take exceeds OUT_W");

endmodule
